// File: rtl/inst_fetch_ctrl.sv
// ============================================================================
// inst_fetch_ctrl : IF-stage ROM sequencer with a prefetch FIFO and redirect flush
// Revision 1.0
// ============================================================================
`default_nettype none

package inst_fetch_ctrl_pkg;
  typedef enum logic {
    CHIP_DISABLE = 1'b0,
    CHIP_ENABLE  = 1'b1
  } chip_status_t;
  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;
endpackage

module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ROM_WORDS  = 131071,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  output chip_status_t rom_ce,
  output inst_addr_t   rom_pc,
  input  inst_t        rom_inst,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [31:0]  out_inst,
  output logic [31:0]  out_pc,
  output logic         out_fault
);

  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [31:0] LAST_PC = 32'(4 * ROM_WORDS - 4);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [31:0]   pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;

  logic [31:0] mem_inst  [FIFO_DEPTH];
  logic [31:0] mem_pc    [FIFO_DEPTH];
  logic        mem_fault [FIFO_DEPTH];

  logic pop, issue, pc_legal, full;

  assign full     = (count == DEPTH_C);
  assign out_valid = (count != '0);
  assign pop      = out_valid & out_ready & ~redirect_valid;
  assign issue    = (state == S_FETCH) & ~redirect_valid & (~full | pop);
  assign pc_legal = (pc[1:0] == 2'b00) && (pc <= LAST_PC);
  assign rom_pc   = pc;

  assign out_inst  = out_valid ? mem_inst[rd_ptr]  : 32'h0;
  assign out_pc    = out_valid ? mem_pc[rd_ptr]    : 32'h0;
  assign out_fault = out_valid ? mem_fault[rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    rom_ce     = CHIP_DISABLE;
    if (redirect_valid) begin
      next_state = S_FETCH;
    end else begin
      case (state)
        S_IDLE:  next_state = S_FETCH;
        S_FETCH: begin
          // An illegal pc never reaches the ROM; it becomes a fault entry instead.
          if (issue && pc_legal) rom_ce = CHIP_ENABLE;
          if (issue && !pc_legal) next_state = S_FAULT;
        end
        S_FAULT: next_state = S_FAULT;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      mem_pc[wr_ptr]    <= pc;
      mem_inst[wr_ptr]  <= pc_legal ? rom_inst : 32'h0;
      mem_fault[wr_ptr] <= ~pc_legal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (issue) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (pc_legal) pc <= pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({issue, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
// ============================================================================
// tb_inst_fetch_ctrl : directed + randomized bench against a queue-based fetch model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch_ctrl;
  import inst_fetch_ctrl_pkg::*;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          ROM_WORDS  = 131071;
  localparam int          FIFO_DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  chip_status_t rom_ce;
  inst_addr_t   rom_pc;
  inst_t        rom_inst;
  logic         redirect_valid = 1'b0;
  logic [31:0]  redirect_pc = 32'h0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [31:0]  out_inst;
  logic [31:0]  out_pc;
  logic         out_fault;

  always #5 clk = ~clk;

  // ROM word k holds 0x1000_0000 + k
  assign rom_inst = 32'h1000_0000 + (rom_pc >> 2);

  inst_fetch_ctrl #(
    .RESET_PC  (RESET_PC),
    .ROM_WORDS (ROM_WORDS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_ce        (rom_ce),
    .rom_pc        (rom_pc),
    .rom_inst      (rom_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_fault     (out_fault)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_idle;
  bit          m_halt;
  bit          m_known = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (longint'(a) <= 4 * longint'(ROM_WORDS) - 4);
  endfunction

  task automatic step(input bit r, input bit rv, input logic [31:0] rp, input bit rdy);
    bit   e_valid, e_pop, e_issue, e_legal;
    ent_t head, e;
    @(negedge clk);
    rst = r; redirect_valid = rv; redirect_pc = rp; out_ready = rdy;
    #1;
    if (m_known) begin
      e_valid = (m_q.size() != 0);
      head    = e_valid ? m_q[0] : '0;
      e_pop   = e_valid && rdy && !rv;
      e_issue = !m_idle && !m_halt && !rv && (m_q.size() < FIFO_DEPTH || e_pop);
      e_legal = legal(m_pc);
      check("out_valid", 32'(out_valid), 32'(e_valid));
      check("out_pc",    out_pc,         head.pc);
      check("out_inst",  out_inst,       head.inst);
      check("out_fault", 32'(out_fault), 32'(head.fault));
      check("rom_pc",    rom_pc,         m_pc);
      check("rom_ce",    32'(rom_ce),    32'(e_issue && e_legal));
      if (r) begin
        m_q.delete(); m_pc = RESET_PC; m_idle = 1; m_halt = 0;
      end else if (rv) begin
        m_q.delete(); m_pc = rp; m_idle = 0; m_halt = 0;
      end else begin
        m_idle = 0;
        if (e_pop) void'(m_q.pop_front());
        if (e_issue) begin
          e.pc    = m_pc;
          e.inst  = e_legal ? 32'h1000_0000 + (m_pc >> 2) : 32'h0;
          e.fault = !e_legal;
          m_q.push_back(e);
          if (e_legal) m_pc = m_pc + 32'd4;
          else         m_halt = 1;
        end
      end
    end else if (r) begin
      m_q.delete(); m_pc = RESET_PC; m_idle = 1; m_halt = 0; m_known = 1;
    end
    @(posedge clk);
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, rdy);
  endtask

  logic [31:0] tgt;

  initial begin
    // reset and streaming
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    run(10, 1);
    // backpressure then drain
    run(5, 0);
    run(6, 1);
    // redirect while full
    run(3, 0);
    step(0, 1, 32'h0000_0100, 1);
    run(5, 1);
    // misaligned target, then recovery
    step(0, 1, 32'h0000_0102, 1);
    run(6, 1);
    step(0, 1, 32'h0000_0000, 1);
    run(4, 1);
    // end of ROM range
    step(0, 1, 32'h0007_FFF8, 1);
    run(6, 1);
    // reset mid-stream with a concurrent redirect
    step(0, 1, 32'h0000_0000, 0);
    run(3, 0);
    step(1, 1, 32'h0000_0200, 1);
    run(8, 1);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       tgt = 32'($urandom_range(0, 63)) * 4;
        1:       tgt = 32'h0007_FFF0 + 32'($urandom_range(0, 3)) * 4;
        2:       tgt = 32'($urandom_range(0, 255));
        default: tgt = 32'h8000_0000 | 32'($urandom_range(0, 1023));
      endcase
      step($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0, tgt,
           $urandom_range(0, 3) != 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
